// File: rtl/mc_ctrl_fsm_pkg.sv
// Shared definitions for the multi-cycle MIPS control unit.
//   - 4-bit state encodings (also exported on the State debug port)
//   - instruction opcodes (IR[31:26])
//   - ALU operation codes, plus AluFunc (4'b1111) = "decode FuncCode"
// Optional feature macro: MC_CTRL_ILOGIC_EN adds ANDI/ORI/XORI/SLTI/SLTIU
// to the immediate-execute path.
package mc_ctrl_fsm_pkg;

  typedef enum logic [3:0] {
    StFetch  = 4'd0,
    StDecode = 4'd1,
    StMemAdr = 4'd2,
    StMemRd  = 4'd3,
    StMemWr  = 4'd4,
    StMemWb  = 4'd5,
    StRex    = 4'd6,
    StRwb    = 4'd7,
    StBr     = 4'd8,
    StJmp    = 4'd9,
    StIex    = 4'd10,
    StIwb    = 4'd11,
    StErr    = 4'd15
  } state_e;

  localparam logic [5:0] OpRtype = 6'b000000;
  localparam logic [5:0] OpJ     = 6'b000010;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpBne   = 6'b000101;
  localparam logic [5:0] OpAddi  = 6'b001000;
  localparam logic [5:0] OpAddiu = 6'b001001;
  localparam logic [5:0] OpSlti  = 6'b001010;
  localparam logic [5:0] OpSltiu = 6'b001011;
  localparam logic [5:0] OpAndi  = 6'b001100;
  localparam logic [5:0] OpOri   = 6'b001101;
  localparam logic [5:0] OpXori  = 6'b001110;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;

  localparam logic [3:0] AluAnd  = 4'd0;
  localparam logic [3:0] AluOr   = 4'd1;
  localparam logic [3:0] AluAdd  = 4'd2;
  localparam logic [3:0] AluAddu = 4'd3;
  localparam logic [3:0] AluXor  = 4'd4;
  localparam logic [3:0] AluSub  = 4'd6;
  localparam logic [3:0] AluSlt  = 4'd7;
  localparam logic [3:0] AluSltu = 4'd8;
  localparam logic [3:0] AluFunc = 4'b1111;

  // Opcodes that execute through IEX/IWB.
  function automatic logic is_iex_op(input logic [5:0] op);
    logic r;
    r = (op == OpAddi) || (op == OpAddiu);
`ifdef MC_CTRL_ILOGIC_EN
    r = r || (op == OpAndi) || (op == OpOri) || (op == OpXori) ||
         (op == OpSlti) || (op == OpSltiu);
`endif
    return r;
  endfunction

  // ALU operation used in IEX for a given immediate opcode.
  function automatic logic [3:0] iex_alu_op(input logic [5:0] op);
    logic [3:0] r;
    r = AluAdd;
    if (op == OpAddiu) r = AluAddu;
`ifdef MC_CTRL_ILOGIC_EN
    if (op == OpAndi)  r = AluAnd;
    if (op == OpOri)   r = AluOr;
    if (op == OpXori)  r = AluXor;
    if (op == OpSlti)  r = AluSlt;
    if (op == OpSltiu) r = AluSltu;
`endif
    return r;
  endfunction

endpackage

// File: rtl/mc_mem_wait.sv
// Memory wait counter with timeout compare.
//   clk_i/rst_i  clock, asynchronous active-high reset
//   clr_i        clear the counter (not in a memory state, or transfer done)
//   en_i         count one more stalled cycle
//   timeout_o    this is the MaxWait-th consecutive stalled cycle
module mc_mem_wait #(
  parameter int unsigned MaxWait = 15
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic timeout_o
);

  localparam logic [7:0] LastCnt = 8'(MaxWait - 1);

  logic [7:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Counter holds the number of stalled cycles already seen, so the stall
  // that would make it MaxWait is the one that times out.
  assign timeout_o = en_i && (cnt_q == LastCnt);

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle MIPS control unit: sequences ALU, memory, IR, PC and register
// file one instruction at a time. Moore outputs decoded from the state
// register, except IRWrite/PCWrite in FETCH (qualified by MemReady) and
// PCWrite in BR (qualified by Zero).
// Ports: CLK, Reset (async, active-high), Opcode, Zero, MemReady in;
//   ALUop, ALUSrcA, ALUSrcB, IorD, MemRead, MemWrite, IRWrite, RegDst,
//   MemtoReg, RegWrite, PCWrite, PCSource, Error, State out.
// Optional feature macro: MC_CTRL_ILOGIC_EN (logical/compare immediates).
module mc_ctrl_fsm
  import mc_ctrl_fsm_pkg::*;
#(
  parameter int unsigned MEM_WAIT_MAX = 15
) (
  input  logic       CLK,
  input  logic       Reset,
  input  logic [5:0] Opcode,
  input  logic       Zero,
  input  logic       MemReady,
  output logic [3:0] ALUop,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic       PCWrite,
  output logic [1:0] PCSource,
  output logic       Error,
  output logic [3:0] State
);

  state_e     state_q, state_d;
  logic [5:0] op_q, op_d;  // opcode captured in DECODE for later states
  logic       mem_state;
  logic       timeout;

  assign mem_state = (state_q == StFetch) || (state_q == StMemRd) || (state_q == StMemWr);

  mc_mem_wait #(
    .MaxWait (MEM_WAIT_MAX)
  ) u_mem_wait (
    .clk_i     (CLK),
    .rst_i     (Reset),
    .clr_i     (!mem_state || MemReady),
    .en_i      (mem_state && !MemReady),
    .timeout_o (timeout)
  );

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state_q <= StFetch;
      op_q    <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
    end
  end

  // Next state. A completed transfer takes priority over a timeout.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    unique case (state_q)
      StFetch: begin
        if (MemReady)     state_d = StDecode;
        else if (timeout) state_d = StErr;
      end
      StDecode: begin
        op_d = Opcode;
        if ((Opcode == OpLw) || (Opcode == OpSw))        state_d = StMemAdr;
        else if (Opcode == OpRtype)                      state_d = StRex;
        else if ((Opcode == OpBeq) || (Opcode == OpBne)) state_d = StBr;
        else if (Opcode == OpJ)                          state_d = StJmp;
        else if (is_iex_op(Opcode))                      state_d = StIex;
        else                                             state_d = StErr;
      end
      StMemAdr: state_d = (op_q == OpSw) ? StMemWr : StMemRd;
      StMemRd: begin
        if (MemReady)     state_d = StMemWb;
        else if (timeout) state_d = StErr;
      end
      StMemWr: begin
        if (MemReady)     state_d = StFetch;
        else if (timeout) state_d = StErr;
      end
      StMemWb: state_d = StFetch;
      StRex:   state_d = StRwb;
      StRwb:   state_d = StFetch;
      StBr:    state_d = StFetch;
      StJmp:   state_d = StFetch;
      StIex:   state_d = StIwb;
      StIwb:   state_d = StFetch;
      default: state_d = StErr;
    endcase
  end

  always_comb begin
    ALUop    = AluAdd;
    ALUSrcA  = 1'b0;
    ALUSrcB  = 2'd0;
    IorD     = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    IRWrite  = 1'b0;
    RegDst   = 1'b0;
    MemtoReg = 1'b0;
    RegWrite = 1'b0;
    PCWrite  = 1'b0;
    PCSource = 2'd0;
    Error    = 1'b0;
    unique case (state_q)
      StFetch: begin
        MemRead = 1'b1;
        ALUSrcB = 2'd1;
        IRWrite = MemReady;
        PCWrite = MemReady;
      end
      StDecode: ALUSrcB = 2'd3;
      StMemAdr: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'd2;
      end
      StMemRd: begin
        IorD    = 1'b1;
        MemRead = 1'b1;
      end
      StMemWr: begin
        IorD     = 1'b1;
        MemWrite = 1'b1;
      end
      StMemWb: begin
        MemtoReg = 1'b1;
        RegWrite = 1'b1;
      end
      StRex: begin
        ALUSrcA = 1'b1;
        ALUop   = AluFunc;
      end
      StRwb: begin
        RegDst   = 1'b1;
        RegWrite = 1'b1;
      end
      StBr: begin
        ALUSrcA  = 1'b1;
        ALUop    = AluSub;
        PCSource = 2'd1;
        PCWrite  = (op_q == OpBne) ? !Zero : Zero;
      end
      StJmp: begin
        PCWrite  = 1'b1;
        PCSource = 2'd2;
      end
      StIex: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'd2;
        ALUop   = iex_alu_op(op_q);
      end
      StIwb:   RegWrite = 1'b1;
      StErr:   Error = 1'b1;
      default: Error = 1'b1;
    endcase
  end

  assign State = state_q;

endmodule
